// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for imm_extend_pipe: immediate request side and
// extended-result side, each with its own valid/ready pair.
interface imm_extend_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  immediate;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] output_imm;

    modport master (
        output in_valid,
        output immediate,
        output mode,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  output_imm
    );

    modport slave (
        input  in_valid,
        input  immediate,
        input  mode,
        input  out_ready,
        output in_ready,
        output out_valid,
        output output_imm
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// Immediate extender (sign/zero/upper/branch) behind a 2-entry in-order buffer.
// Define IMM_EXT_STATS_EN to add the saturating xfer_count output.
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    imm_extend_pipe_if.slave  bus
`ifdef IMM_EXT_STATS_EN
    ,
    output logic [15:0]       xfer_count
`endif
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic [OUT_W-1:0] head;
    logic [OUT_W-1:0] tail;
    logic             out_valid_r;
    logic             in_ready_r;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] ext;
    logic             push;
    logic             pop;

    assign push = bus.in_valid & in_ready_r;
    assign pop  = out_valid_r & bus.out_ready;

    always_comb begin
        sext = {{(OUT_W-IN_W){bus.immediate[IN_W-1]}}, bus.immediate};
        ext  = sext;
        case (bus.mode)
            2'b00:   ext = sext;
            2'b01:   ext = {{(OUT_W-IN_W){1'b0}}, bus.immediate};
            2'b10:   ext = {bus.immediate, {(OUT_W-IN_W){1'b0}}};
            default: ext = sext << 2;
        endcase
    end

    // head is kept zero while empty so output_imm reads zero without a mux
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= EMPTY;
            head        <= '0;
            tail        <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else if (flush) begin
            state       <= EMPTY;
            head        <= '0;
            tail        <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        head        <= ext;
                        state       <= ONE;
                        out_valid_r <= 1'b1;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head <= ext;
                    end else if (push) begin
                        tail       <= ext;
                        state      <= FULL;
                        in_ready_r <= 1'b0;
                    end else if (pop) begin
                        head        <= '0;
                        state       <= EMPTY;
                        out_valid_r <= 1'b0;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head       <= tail;
                        tail       <= '0;
                        state      <= ONE;
                        in_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    head        <= '0;
                    tail        <= '0;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.output_imm = head;

`ifdef IMM_EXT_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xfer_count <= '0;
        end else if (pop && xfer_count != 16'hFFFF) begin
            xfer_count <= xfer_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed self-checking bench for imm_extend_pipe.
// Covers modes, backpressure, streaming, flush and async reset.
module tb_imm_extend_pipe;
    logic clk;
    logic reset;
    logic flush;
    int   n_checks;
    int   n_fail;

    imm_extend_pipe_if #(.IN_W(16), .OUT_W(32)) bus ();

`ifdef IMM_EXT_STATS_EN
    logic [15:0] xfer_count;
`endif

    imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
`ifdef IMM_EXT_STATS_EN
        ,
        .xfer_count (xfer_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        flush = 1'b0;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.immediate = '0;
        bus.mode = 2'b00;
        bus.out_ready = 1'b0;
        step();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid got %b exp 0", bus.out_valid);
        end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready got %b exp 1", bus.in_ready);
        end
        n_checks++;
        if (bus.output_imm !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_output got %h exp 0", bus.output_imm);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic run_stream(string name, logic [15:0] imms[4],
                              logic [1:0] modes[4], logic [31:0] exps[4],
                              int n);
        bus.out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.immediate = imms[i];
            bus.mode = modes[i];
            step();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.output_imm !== exps[i]) begin
                n_fail++;
                $display("FAIL %s[%0d] got v=%b %h exp v=1 %h", name, i,
                         bus.out_valid, bus.output_imm, exps[i]);
            end
        end
        bus.in_valid = 1'b0;
        step();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.output_imm !== 32'h0) begin
            n_fail++;
            $display("FAIL %s_drain got v=%b %h exp v=0 0", name,
                     bus.out_valid, bus.output_imm);
        end
    endtask

    task automatic test_modes();
        logic [15:0] imms[4];
        logic [1:0]  modes[4];
        logic [31:0] exps[4];
        imms  = '{16'h1111, 16'hFFFF, 16'hFFFF, 16'hF000};
        modes = '{2'b00, 2'b00, 2'b01, 2'b10};
        exps  = '{32'h00001111, 32'hFFFFFFFF, 32'h0000FFFF, 32'hF0000000};
        run_stream("modes", imms, modes, exps, 4);
    endtask

    task automatic test_branch();
        logic [15:0] imms[4];
        logic [1:0]  modes[4];
        logic [31:0] exps[4];
        imms  = '{16'hFFFF, 16'h4000, 16'h8000, 16'h0001};
        modes = '{2'b11, 2'b11, 2'b11, 2'b11};
        exps  = '{32'hFFFFFFFC, 32'h00010000, 32'hFFFE0000, 32'h00000004};
        run_stream("branch", imms, modes, exps, 4);
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        bus.mode = 2'b00;
        bus.in_valid = 1'b1;
        bus.immediate = 16'h0001;
        step();
        bus.immediate = 16'h0002;
        step();
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full_ready got %b exp 0", bus.in_ready);
        end
        bus.immediate = 16'h0003;
        step();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.output_imm !== 32'h1
            || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold got v=%b %h r=%b exp v=1 1 r=0",
                     bus.out_valid, bus.output_imm, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        step();
        n_checks++;
        if (bus.output_imm !== 32'h2 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_second got %h r=%b exp 2 r=1",
                     bus.output_imm, bus.in_ready);
        end
        step();
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.output_imm !== 32'h3) begin
            n_fail++;
            $display("FAIL bp_third got v=%b %h exp v=1 3",
                     bus.out_valid, bus.output_imm);
        end
        step();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain got %b exp 0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        bus.out_ready = 1'b1;
        bus.mode = 2'b01;
        for (int i = 0; i < 11; i++) begin
            bus.in_valid = 1'b1;
            bus.immediate = 16'h8020 + 16'(i);
            exp = 32'h00008020 + 32'(i);
            step();
            n_checks++;
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1
                || bus.output_imm !== exp) begin
                n_fail++;
                $display("FAIL b2b[%0d] got r=%b v=%b %h exp r=1 v=1 %h",
                         i, bus.in_ready, bus.out_valid,
                         bus.output_imm, exp);
            end
        end
        bus.in_valid = 1'b0;
        step();
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        bus.mode = 2'b00;
        bus.in_valid = 1'b1;
        bus.immediate = 16'h0005;
        step();
        bus.immediate = 16'h0006;
        step();
        bus.immediate = 16'h0077;
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1
            || bus.output_imm !== 32'h0) begin
            n_fail++;
            $display("FAIL flush got v=%b r=%b %h exp v=0 r=1 0",
                     bus.out_valid, bus.in_ready, bus.output_imm);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_leak[%0d] got v=%b %h exp v=0",
                         i, bus.out_valid, bus.output_imm);
            end
        end
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        bus.mode = 2'b00;
        bus.in_valid = 1'b1;
        bus.immediate = 16'h0009;
        step();
        bus.immediate = 16'h000A;
        step();
        bus.in_valid = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1
            || bus.output_imm !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset got v=%b r=%b %h exp v=0 r=1 0",
                     bus.out_valid, bus.in_ready, bus.output_imm);
        end
        #1;
        reset = 1'b0;
        step();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.immediate = 16'h9234;
        step();
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.output_imm !== 32'hFFFF9234) begin
            n_fail++;
            $display("FAIL post_reset got v=%b %h exp v=1 ffff9234",
                     bus.out_valid, bus.output_imm);
        end
        step();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_drain got %b exp 0", bus.out_valid);
        end
    endtask

`ifdef IMM_EXT_STATS_EN
    task automatic test_stats();
        do_reset();
        bus.out_ready = 1'b1;
        bus.mode = 2'b01;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.immediate = 16'(i);
            step();
        end
        bus.in_valid = 1'b0;
        step();
        n_checks++;
        if (xfer_count !== 16'd5) begin
            n_fail++;
            $display("FAIL stats_count got %0d exp 5", xfer_count);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_checks++;
        if (xfer_count !== 16'd5) begin
            n_fail++;
            $display("FAIL stats_flush got %0d exp 5", xfer_count);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (xfer_count !== 16'd0) begin
            n_fail++;
            $display("FAIL stats_reset got %0d exp 0", xfer_count);
        end
        reset = 1'b0;
        step();
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_modes();
        test_branch();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_async_reset();
`ifdef IMM_EXT_STATS_EN
        test_stats();
`endif
        do_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 Parameter IN_W, default 16, immediate field width in bits.
REQ-002 Parameter OUT_W, default 32, extended result width in bits; the block SHALL support any OUT_W >= IN_W+2.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  synchronous discard of all buffered results.
REQ-006 in_valid  input  1  immediate and mode are valid this cycle.
REQ-007 in_ready  output  1  block accepts input this cycle.
REQ-008 immediate  input  IN_W  raw immediate field.
REQ-009 mode  input  2  extension mode: 00 sign, 01 zero, 10 upper-load, 11 branch offset.
REQ-010 out_valid  output  1  output_imm holds a valid result.
REQ-011 out_ready  input  1  consumer accepts result this cycle.
REQ-012 output_imm  output  OUT_W  extended result at buffer head.

Function
REQ-013 Mode 00 SHALL replicate immediate[IN_W-1] into bits OUT_W-1..IN_W.
REQ-014 Mode 01 SHALL zero-fill bits OUT_W-1..IN_W.
REQ-015 Mode 10 SHALL place immediate in bits OUT_W-1..OUT_W-IN_W, remaining low bits zero.
REQ-016 Mode 11 SHALL sign-extend as in mode 00, then shift left by 2, discarding bits shifted past OUT_W-1, with bits 1..0 zero.
REQ-017 An input transfer SHALL occur on a cycle with in_valid=1 and in_ready=1; an output transfer on a cycle with out_valid=1 and out_ready=1.
REQ-018 Results SHALL be held in a 2-entry in-order buffer; state machine states EMPTY, ONE, FULL.
REQ-019 Latency: a result accepted in cycle N SHALL appear with out_valid=1 in cycle N+1 when the buffer was EMPTY.
REQ-020 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, with no combinational dependency on out_ready.
REQ-021 out_valid SHALL be 1 in ONE and FULL, 0 in EMPTY.
REQ-022 Transitions: EMPTY->ONE on push; ONE->FULL on push without pop; ONE->EMPTY on pop without push; ONE stays ONE on simultaneous push and pop; FULL->ONE on pop.
REQ-023 Results SHALL leave in acceptance order; output_imm and out_valid SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 flush=1 SHALL force EMPTY next cycle and discard any same-cycle input transfer; flush has priority over push and pop.
REQ-025 When out_valid=0, output_imm SHALL be all zeros.
REQ-026 Input fields SHALL be ignored when no input transfer occurs.

Reset
REQ-027 reset=1 SHALL immediately force EMPTY, out_valid=0, output_imm=0, in_ready=1, independent of clk.
REQ-028 Reset mid-operation SHALL discard all buffered results; the first transfer after reset deassertion SHALL behave as from EMPTY.

Configuration
REQ-029 Macro IMM_EXT_STATS_EN, when defined, SHALL add output port xfer_count (16 bits) counting output transfers, saturating at 16'hFFFF, cleared by reset, unaffected by flush.
REQ-030 Without IMM_EXT_STATS_EN the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-031 Defaults, out_ready=1: push 16'h1111/00, 16'hFFFF/00, 16'hFFFF/01, 16'hF000/10 -> outputs 32'h00001111, 32'hFFFFFFFF, 32'h0000FFFF, 32'hF0000000, each one cycle after acceptance.
REQ-032 Branch mode: push 16'hFFFF/11 -> 32'hFFFFFFFC; push 16'h4000/11 -> 32'h00010000; push 16'h8000/11 -> 32'hFFFE0000.
REQ-033 Backpressure: out_ready=0, offer three inputs 16'h0001..16'h0003 in mode 00 -> first two accepted, in_ready=0 after second; release out_ready -> 32'h00000001, 32'h00000002, then 32'h00000003 accepted and output, order preserved.
REQ-034 Simultaneous push and pop in ONE for 10 cycles -> one result per cycle, in_ready never 0.
REQ-035 FULL, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed input never output; assert reset asynchronously mid-stream -> out_valid=0 before next clock edge.
REQ-036 With IMM_EXT_STATS_EN, 5 output transfers -> xfer_count=5; flush leaves it 5; reset clears it to 0.
